// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: in-order instruction fetch into a DEPTH-entry {pc, instr} buffer feeding decode.
// Optional: define FETCH_MISALIGN_CHECK_EN to turn misaligned PCs into zero-filled, flagged entries with no fetch.
module instr_fetch_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        redirect,
   output logic        pc_advance,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_misaligned
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d, pend_q, pend_d, disc_q, disc_d;
   logic [31:0]      pc_q [DEPTH];
   logic [31:0]      pc_d [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_d [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d, mis_q, mis_d;

   logic          misal, alloc_ok, fire, pop, resp_take, resp_stale, fill_hit;
   logic [PW-1:0] fill_idx;
   logic [CW:0]   inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misal = (pc_in[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif

   // Memory reads still in flight: live (pend) plus stale ones left over from a redirect.
   assign inflight = {1'b0, pend_q} + {1'b0, disc_q};

   assign alloc_ok = rst_n && !redirect && (count_q < CW'(DEPTH))
                     && (misal || (inflight < (CW+1)'(DEPTH)));
   assign imem_req_valid = alloc_ok && !misal;
   assign imem_req_addr  = pc_in;
   assign fire           = alloc_ok && (misal || imem_req_ready);
   assign pc_advance     = fire;

   assign if_valid      = (count_q != '0) && filled_q[head_q] && !redirect;
   assign if_pc         = pc_q[head_q];
   assign if_instr      = instr_q[head_q];
   assign if_misaligned = mis_q[head_q];
   assign pop           = if_valid && if_ready;

   // Oldest allocated entry still waiting for its memory word.
   always_comb begin
      fill_hit = 1'b0;
      fill_idx = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (!fill_hit && (CW'(i) < count_q) && !filled_q[head_q + PW'(i)]) begin
            fill_hit = 1'b1;
            fill_idx = head_q + PW'(i);
         end
      end
   end

   assign resp_stale = imem_resp_valid && (disc_q != '0);
   assign resp_take  = imem_resp_valid && !redirect && (disc_q == '0) && fill_hit;

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      pend_d   = pend_q;
      disc_d   = disc_q;
      filled_d = filled_q;
      mis_d    = mis_q;
      for (int i = 0; i < DEPTH; i++) begin
         pc_d[i]    = pc_q[i];
         instr_d[i] = instr_q[i];
      end

      if (redirect) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         pend_d   = '0;
         filled_d = '0;
         // Everything still in flight becomes stale, minus a response landing this cycle.
         disc_d   = CW'(inflight - (CW+1)'(imem_resp_valid && (inflight != '0)));
      end else begin
         if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + PW'(1);
         end
         if (fire) begin
            pc_d[tail_q]     = pc_in;
            instr_d[tail_q]  = '0;
            filled_d[tail_q] = misal;
            mis_d[tail_q]    = misal;
            tail_d           = tail_q + PW'(1);
         end
         if (resp_take) begin
            instr_d[fill_idx]  = imem_resp_data;
            filled_d[fill_idx] = 1'b1;
         end
         count_d = count_q + CW'(fire) - CW'(pop);
         pend_d  = pend_q + CW'(fire && !misal) - CW'(resp_take);
         disc_d  = disc_q - CW'(resp_stale);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         pend_q   <= '0;
         disc_q   <= '0;
         filled_q <= '0;
         mis_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         disc_q   <= disc_d;
         filled_q <= filled_d;
         mis_q    <= mis_d;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= pc_d[i];
            instr_q[i] <= instr_d[i];
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue-based reference model plus directed literal checks and random traffic.
// Honours FETCH_MISALIGN_CHECK_EN the same way as the design.
module tb_instr_fetch_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] pc_in = '0;
   logic        redirect = 1'b0;
   logic        pc_advance;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_misaligned;

   always #5 clk = ~clk;

   instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .redirect(redirect),
      .pc_advance(pc_advance), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_instr(if_instr), .if_misaligned(if_misaligned)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; bit mis; } ent_t;
   typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
   typedef struct { int cyc; logic [31:0] pc; logic [31:0] instr; } acc_t;

   ent_t bq[$];
   req_t mq[$];
   acc_t acc_log[$];

   int          n_pass = 0, n_total = 0;
   int          cyc = 0, last_due = 0, adv_cnt = 0;
   logic [31:0] pc_reg = '0;
   bit          k_redirect, k_req_ready, k_if_ready, k_spur;
   logic [31:0] k_target;
   int          k_lat = 1;
   bit          obs_req, obs_adv, obs_ifv, obs_mis;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a + 32'hA0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock: drive at negedge, compare against the model, advance the model.
   task automatic step();
      bit resp, mis, ok, e_req, e_fire, e_ifv;
      logic [31:0] rdata;
      int cnt, d;
      req_t r;
      ent_t e;
      acc_t a;
      resp  = (mq.size() > 0) && (mq[0].due <= cyc);
      rdata = resp ? mem_data(mq[0].addr) : $urandom;
      if (!resp && k_spur && mq.size() == 0) resp = ($urandom_range(0, 3) == 0);
      pc_in = pc_reg; redirect = k_redirect; imem_req_ready = k_req_ready;
      if_ready = k_if_ready; imem_resp_valid = resp; imem_resp_data = rdata;
      #1;
      cnt = bq.size();
`ifdef FETCH_MISALIGN_CHECK_EN
      mis = (pc_reg[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      ok     = !k_redirect && (cnt < DEPTH) && (mis || mq.size() < DEPTH);
      e_req  = ok && !mis;
      e_fire = ok && (mis || k_req_ready);
      e_ifv  = (cnt > 0) && bq[0].filled && !k_redirect;
      obs_req = imem_req_valid; obs_adv = pc_advance; obs_ifv = if_valid;
      obs_addr = imem_req_addr; obs_pc = if_pc; obs_instr = if_instr; obs_mis = if_misaligned;
      if (pc_advance) adv_cnt++;
      check("req_valid", 32'(imem_req_valid), 32'(e_req));
      check("req_addr", imem_req_addr, pc_reg);
      check("pc_advance", 32'(pc_advance), 32'(e_fire));
      check("if_valid", 32'(if_valid), 32'(e_ifv));
      if (e_ifv) begin
         check("if_pc", if_pc, bq[0].pc);
         check("if_instr", if_instr, bq[0].instr);
         check("if_misaligned", 32'(if_misaligned), 32'(bq[0].mis));
      end
      if (resp && mq.size() > 0) begin
         r = mq.pop_front();
         if (!r.stale && !k_redirect) begin
            for (int i = 0; i < bq.size(); i++) begin
               if (!bq[i].filled) begin
                  bq[i].instr = rdata;
                  bq[i].filled = 1'b1;
                  break;
               end
            end
         end
      end
      if (k_redirect) begin
         foreach (mq[i]) mq[i].stale = 1'b1;
         bq.delete();
         pc_reg = k_target;
      end else begin
         if (e_ifv && k_if_ready) begin
            a.cyc = cyc; a.pc = bq[0].pc; a.instr = bq[0].instr;
            acc_log.push_back(a);
            void'(bq.pop_front());
         end
         if (e_fire) begin
            e.pc = pc_reg; e.instr = '0; e.filled = mis; e.mis = mis;
            bq.push_back(e);
            if (!mis) begin
               d = cyc + k_lat;
               if (d <= last_due) d = last_due + 1;
               last_due = d;
               r.addr = pc_reg; r.due = d; r.stale = 1'b0;
               mq.push_back(r);
            end
            pc_reg = pc_reg + 32'd4;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         redirect = 1'($urandom); imem_req_ready = 1'($urandom); if_ready = 1'($urandom);
         pc_in = $urandom; imem_resp_valid = i[0]; imem_resp_data = $urandom;
         #1;
         check("rst_req_valid", 32'(imem_req_valid), 32'd0);
         check("rst_pc_advance", 32'(pc_advance), 32'd0);
         check("rst_if_valid", 32'(if_valid), 32'd0);
         check("rst_if_misaligned", 32'(if_misaligned), 32'd0);
         check("rst_if_pc", if_pc, 32'd0);
         check("rst_if_instr", if_instr, 32'd0);
         @(negedge clk);
         cyc++;
      end
      bq.delete(); mq.delete();
      rst_n = 1'b1;
   endtask

   function automatic int count_pc(input logic [31:0] lo, input logic [31:0] hi);
      int n = 0;
      foreach (acc_log[i]) if (acc_log[i].pc >= lo && acc_log[i].pc <= hi) n++;
      return n;
   endfunction

   initial begin
      int s;
      #2;
      do_reset(6);
      k_redirect = 0; k_spur = 0; k_target = '0;

      // Streaming at PC 0 with a 1-cycle memory.
      pc_reg = 32'h0; k_req_ready = 1; k_if_ready = 1; k_lat = 1;
      acc_log.delete(); s = cyc;
      repeat (6) step();
      check("stream_count", 32'(acc_log.size() >= 3), 32'd1);
      check("stream0_cyc", 32'(acc_log[0].cyc - s), 32'd2);
      check("stream0_pc", acc_log[0].pc, 32'h0);
      check("stream0_instr", acc_log[0].instr, 32'hA0);
      check("stream1_cyc", 32'(acc_log[1].cyc - s), 32'd3);
      check("stream1_pc", acc_log[1].pc, 32'h4);
      check("stream1_instr", acc_log[1].instr, 32'hA4);
      check("stream2_cyc", 32'(acc_log[2].cyc - s), 32'd4);
      check("stream2_pc", acc_log[2].pc, 32'h8);
      check("stream2_instr", acc_log[2].instr, 32'hA8);

      // Backpressure: decode stalled fills the buffer, one pop lets one more request through.
      do_reset(2);
      pc_reg = 32'h40; k_req_ready = 1; k_if_ready = 0; k_lat = 1; adv_cnt = 0;
      repeat (8) step();
      check("bp_fires", 32'(adv_cnt), 32'(DEPTH));
      check("bp_stall", 32'(obs_req), 32'd0);
      k_if_ready = 1; step();
      check("bp_pop_cycle_req", 32'(obs_req), 32'd0);
      k_if_ready = 0; step();
      check("bp_resume_req", 32'(obs_req), 32'd1);
      check("bp_resume_fires", 32'(adv_cnt), 32'(DEPTH + 1));

      // Flush with two slow fetches outstanding.
      do_reset(2);
      pc_reg = 32'h10; k_req_ready = 1; k_if_ready = 1; k_lat = 4;
      step(); step();
      k_redirect = 1; k_target = 32'h100; step();
      k_redirect = 0; k_lat = 1; acc_log.delete();
      repeat (12) step();
      check("flush_first_pc", acc_log[0].pc, 32'h100);
      check("flush_first_instr", acc_log[0].instr, 32'h1A0);
      check("flush_no_stale", 32'(count_pc(32'h10, 32'h14)), 32'd0);

      // Redirect together with a response and if_ready.
      do_reset(2);
      pc_reg = 32'h200; k_req_ready = 1; k_if_ready = 0;
      k_lat = 1; step();
      k_lat = 2; step();
      k_lat = 4; step();
      check("sim_head_ready", 32'(obs_ifv), 32'd1);
      k_redirect = 1; k_target = 32'h300; k_if_ready = 1; acc_log.delete(); step();
      check("sim_no_pop", 32'(obs_ifv), 32'd0);
      k_redirect = 0; k_lat = 1;
      repeat (12) step();
      check("sim_first_pc", acc_log[0].pc, 32'h300);
      check("sim_first_instr", acc_log[0].instr, 32'h3A0);
      check("sim_no_stale", 32'(count_pc(32'h200, 32'h208)), 32'd0);

      // Misaligned PC.
      do_reset(2);
      pc_reg = 32'h102; k_req_ready = 1; k_if_ready = 1; k_lat = 1;
      step();
      check("mis_addr", obs_addr, 32'h102);
      check("mis_adv", 32'(obs_adv), 32'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mis_req", 32'(obs_req), 32'd0);
      step();
      check("mis_valid", 32'(obs_ifv), 32'd1);
      check("mis_pc", obs_pc, 32'h102);
      check("mis_instr", obs_instr, 32'h0);
      check("mis_flag", 32'(obs_mis), 32'd1);
`else
      check("mis_req", 32'(obs_req), 32'd1);
      step(); step();
      check("mis_valid", 32'(obs_ifv), 32'd1);
      check("mis_pc", obs_pc, 32'h102);
      check("mis_instr", obs_instr, 32'h1A2);
      check("mis_flag", 32'(obs_mis), 32'd0);
`endif

      // Random traffic with redirects, stalls, spurious responses and occasional resets.
      do_reset(3);
      pc_reg = 32'h1000; k_spur = 1;
      for (int t = 0; t < 3000; t++) begin
         k_redirect  = ($urandom_range(0, 15) == 0);
         k_target    = (32'($urandom_range(0, 1023)) << 2) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
         k_req_ready = ($urandom_range(0, 3) != 0);
         k_if_ready  = ($urandom_range(0, 3) != 0);
         k_lat       = $urandom_range(1, 4);
         if ($urandom_range(0, 499) == 0) do_reset(2);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
